// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline stage.
//   XLEN / RA_W   : datapath and register-address widths
//   LS_*          : funct3 load/store size codes carried to MEM
//   ex_mem_t      : payload registered between EX and MEM
//   fifo_state_e  : occupancy state of the 2-entry skid buffer
//   branch_taken  : branch/jump resolution rule
package ex_mem_stage_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [2:0] LS_B = 3'b000;
   localparam logic [2:0] LS_H = 3'b001;
   localparam logic [2:0] LS_W = 3'b010;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] store_data;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      funct3;
   } ex_mem_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   // br_inv selects the "Zero clear" flavour (BNE/BLT/BLTU).
   function automatic logic branch_taken(input logic jump, input logic branch,
                                         input logic zero, input logic inv);
      return jump | (branch & (zero ^ inv));
   endfunction

endpackage

// File: rtl/ex_mem_stage_skid_fifo2.sv
// Generic 2-entry valid/ready buffer. The head register drives the output
// directly; the tail register catches the beat that arrives while the head
// is stalled, so the upstream ready can be a pure function of state.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload (= head)
module skid_fifo2
   import ex_mem_stage_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   fifo_state_e  state, state_nxt;
   logic [W-1:0] head_p1;
   logic [W-1:0] tail_p1;
   logic         acc;
   logic         cons;

   // in_ready depends only on the state register, never on out_ready.
   assign in_ready  = (state != FIFO_FULL);
   assign out_valid = (state != FIFO_EMPTY);
   assign out_data  = head_p1;
   assign acc       = in_valid && in_ready;
   assign cons      = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= FIFO_EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FIFO_EMPTY: if (acc) state_nxt = FIFO_ONE;
         FIFO_ONE: begin
            if (acc && !cons)      state_nxt = FIFO_FULL;
            else if (!acc && cons) state_nxt = FIFO_EMPTY;
         end
         FIFO_FULL:  if (cons) state_nxt = FIFO_ONE;
         default:    state_nxt = FIFO_EMPTY;
      endcase
   end

   // ---- storage stage: head advances only when empty or consumed ----
   always_ff @(posedge clk) begin
      if (reset) begin
         head_p1 <= '0;
         tail_p1 <= '0;
      end else begin
         case (state)
            FIFO_EMPTY: if (acc) head_p1 <= in_data;
            FIFO_ONE: begin
               if (acc && cons) head_p1 <= in_data;
               else if (acc)    tail_p1 <= in_data;
            end
            FIFO_FULL:  if (cons) head_p1 <= tail_p1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage. Registers the ALU result and MEM/WB control,
// resolves branches from the Zero flag and emits a one-cycle PC redirect
// (or a misaligned-target exception) for taken branches and jumps.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : EX handshake
//   alu_result..pc_plus4       : EX beat fields
//   out_valid/out_ready        : MEM handshake
//   out_result..out_funct3     : registered MEM beat fields
//   redirect_valid/redirect_pc : fetch redirect pulse and target
//   misalign_exc               : pulse for a taken, non-word-aligned target
module ex_mem_stage
   import ex_mem_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] store_data,
   input  logic [RA_W-1:0] rd,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic            branch,
   input  logic            br_inv,
   input  logic            jump,
   input  logic [XLEN-1:0] target_pc,
   input  logic [XLEN-1:0] pc_plus4,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [RA_W-1:0] out_rd,
   output logic            out_reg_write,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic [2:0]      out_funct3,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            misalign_exc
);

   localparam int PW = $bits(ex_mem_t);

   logic                   shadow_p0;
   logic                   push_p0;
   logic                   acc_p0;
   logic                   taken_p0;
   logic                   misal_p0;
   ex_mem_t                beat_p0;
   logic [PW-1:0]          beat_bits_p0;
   logic [PW-1:0]          head_bits_p1;
   ex_mem_t                head_p1;

   // ---- EX side: resolve branch and build the payload ----
   // While a redirect/exception pulse is out, the offered beat was fetched
   // down the wrong path: it is dropped here but in_ready is left alone.
   assign shadow_p0 = redirect_valid | misalign_exc;
   assign push_p0   = in_valid && !shadow_p0;
   assign acc_p0    = push_p0 && in_ready;
   assign taken_p0  = branch_taken(jump, branch, alu_zero, br_inv);
   assign misal_p0  = (target_pc[1:0] != 2'b00);

   always_comb begin
      beat_p0.result     = jump ? pc_plus4 : alu_result;
      beat_p0.store_data = store_data;
      beat_p0.rd         = rd;
      beat_p0.reg_write  = reg_write;
      beat_p0.mem_read   = mem_read;
      beat_p0.mem_write  = mem_write;
      beat_p0.funct3     = funct3;
      // A faulting control transfer must not retire any side effect.
      if (taken_p0 && misal_p0) begin
         beat_p0.reg_write = 1'b0;
         beat_p0.mem_read  = 1'b0;
         beat_p0.mem_write = 1'b0;
      end
   end

   assign beat_bits_p0 = beat_p0;

   skid_fifo2 #(.W(PW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (push_p0),
      .in_ready  (in_ready),
      .in_data   (beat_bits_p0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_bits_p1)
   );

   // ---- redirect stage: one-cycle pulse after acceptance ----
   always_ff @(posedge clk) begin
      if (reset) begin
         redirect_valid <= 1'b0;
         misalign_exc   <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= acc_p0 && taken_p0 && !misal_p0;
         misalign_exc   <= acc_p0 && taken_p0 && misal_p0;
         if (acc_p0 && taken_p0) redirect_pc <= target_pc;
      end
   end

   // ---- MEM side: head entry fields ----
   assign head_p1        = ex_mem_t'(head_bits_p1);
   assign out_result     = head_p1.result;
   assign out_store_data = head_p1.store_data;
   assign out_rd         = head_p1.rd;
   assign out_reg_write  = head_p1.reg_write;
   assign out_mem_read   = head_p1.mem_read;
   assign out_mem_write  = head_p1.mem_write;
   assign out_funct3     = head_p1.funct3;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic        branch;
   logic        br_inv;
   logic        jump;
   logic [31:0] target_pc;
   logic [31:0] pc_plus4;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;
   logic [2:0]  out_funct3;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_exc;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [2:0]  f3;
   } exp_t;

   ex_mem_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .alu_zero(alu_zero), .store_data(store_data),
      .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .branch(branch), .br_inv(br_inv), .jump(jump),
      .target_pc(target_pc), .pc_plus4(pc_plus4), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_funct3(out_funct3),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .misalign_exc(misalign_exc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      in_valid = 0; alu_result = 0; alu_zero = 0; store_data = 0; rd = 0;
      reg_write = 0; mem_read = 0; mem_write = 0; funct3 = 0; branch = 0;
      br_inv = 0; jump = 0; target_pc = 0; pc_plus4 = 0;
   endtask

   task automatic set_alu(input logic [31:0] res, input logic [4:0] r);
      set_idle();
      in_valid = 1; alu_result = res; rd = r; reg_write = 1;
   endtask

   task automatic test_reset();
      set_idle();
      out_ready = 1;
      reset = 1;
      tick(); tick();
      reset = 0;
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL rst_redirect got %b exp 0", redirect_valid); end
      n_checks++; if (misalign_exc !== 1'b0) begin n_errors++; $display("FAIL rst_misalign got %b exp 0", misalign_exc); end
      n_checks++; if (out_result !== 32'h0 || out_rd !== 5'd0) begin n_errors++; $display("FAIL rst_data got %h/%0d exp 0/0", out_result, out_rd); end
   endtask

   task automatic test_add();
      out_ready = 1;
      set_alu(32'h0000_0005, 5'd3);
      tick();
      set_idle();
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
      n_checks++; if (out_result !== 32'h5) begin n_errors++; $display("FAIL add_result got %h exp 5", out_result); end
      n_checks++; if (out_rd !== 5'd3 || out_reg_write !== 1'b1) begin n_errors++; $display("FAIL add_rd got %0d/%b exp 3/1", out_rd, out_reg_write); end
      n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL add_redirect got %b exp 0", redirect_valid); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_beq();
      out_ready = 1;
      set_idle();
      in_valid = 1; branch = 1; alu_zero = 1; br_inv = 0; target_pc = 32'h100; alu_result = 32'h77;
      tick();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin n_errors++; $display("FAIL beq_redirect got %b/%h exp 1/100", redirect_valid, redirect_pc); end
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h77) begin n_errors++; $display("FAIL beq_beat got %b/%h exp 1/77", out_valid, out_result); end
      // wrong-path beat in the shadow cycle
      set_alu(32'hDEAD, 5'd9);
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL beq_shadow_ready got %b exp 1", in_ready); end
      tick();
      set_idle();
      n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL beq_pulse got %b exp 0", redirect_valid); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL beq_shadow_drop got valid=%b result=%h exp valid 0", out_valid, out_result); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL beq_shadow_late got %b exp 0", out_valid); end
   endtask

   task automatic test_bne();
      out_ready = 1;
      set_idle();
      in_valid = 1; branch = 1; alu_zero = 1; br_inv = 1; target_pc = 32'h200; alu_result = 32'h1234;
      tick();
      set_idle();
      n_checks++; if (redirect_valid !== 1'b0 || misalign_exc !== 1'b0) begin n_errors++; $display("FAIL bne_redirect got %b/%b exp 0/0", redirect_valid, misalign_exc); end
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234 || out_reg_write !== 1'b0) begin n_errors++; $display("FAIL bne_beat got %b/%h/%b exp 1/1234/0", out_valid, out_result, out_reg_write); end
      tick();
   endtask

   task automatic test_jal();
      out_ready = 1;
      set_idle();
      in_valid = 1; jump = 1; pc_plus4 = 32'h24; target_pc = 32'h40; alu_result = 32'h999; rd = 5'd1; reg_write = 1;
      tick();
      set_idle();
      n_checks++; if (out_result !== 32'h24 || out_reg_write !== 1'b1) begin n_errors++; $display("FAIL jal_link got %h/%b exp 24/1", out_result, out_reg_write); end
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin n_errors++; $display("FAIL jal_redirect got %b/%h exp 1/40", redirect_valid, redirect_pc); end
      tick();
      n_checks++; if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL jal_pulse got %b exp 0", redirect_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, c;
      a = $urandom(); b = $urandom(); c = $urandom();
      out_ready = 0;
      set_alu(a, 5'd1);
      tick();
      n_checks++; if (in_ready !== 1'b1 || out_result !== a) begin n_errors++; $display("FAIL bp_a got ready %b res %h exp 1/%h", in_ready, out_result, a); end
      set_alu(b, 5'd2);
      tick();
      n_checks++; if (in_ready !== 1'b0 || out_result !== a) begin n_errors++; $display("FAIL bp_full got ready %b res %h exp 0/%h", in_ready, out_result, a); end
      set_alu(c, 5'd3);
      tick(); tick();
      n_checks++; if (in_ready !== 1'b0 || out_result !== a || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_stall got ready %b res %h exp 0/%h", in_ready, out_result, a); end
      out_ready = 1;
      tick();
      n_checks++; if (out_result !== b || out_rd !== 5'd2 || in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_b got %h/%0d ready %b exp %h/2 ready 1", out_result, out_rd, in_ready, b); end
      tick();
      set_idle();
      n_checks++; if (out_result !== c || out_rd !== 5'd3 || out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_c got %h/%0d exp %h/3", out_result, out_rd, c); end
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_misalign();
      out_ready = 1;
      set_idle();
      in_valid = 1; jump = 1; target_pc = 32'h42; pc_plus4 = 32'h30; reg_write = 1; mem_write = 1; mem_read = 1; rd = 5'd7;
      tick();
      set_idle();
      n_checks++; if (misalign_exc !== 1'b1 || redirect_valid !== 1'b0) begin n_errors++; $display("FAIL mis_pulse got exc %b redir %b exp 1/0", misalign_exc, redirect_valid); end
      n_checks++; if (out_reg_write !== 1'b0 || out_mem_write !== 1'b0 || out_mem_read !== 1'b0) begin n_errors++; $display("FAIL mis_squash got %b%b%b exp 000", out_reg_write, out_mem_read, out_mem_write); end
      n_checks++; if (out_valid !== 1'b1 || out_result !== 32'h30) begin n_errors++; $display("FAIL mis_beat got %b/%h exp 1/30", out_valid, out_result); end
      tick();
      n_checks++; if (misalign_exc !== 1'b0) begin n_errors++; $display("FAIL mis_end got %b exp 0", misalign_exc); end
   endtask

   task automatic test_reset_full();
      out_ready = 0;
      set_alu(32'hAAAA, 5'd4);
      tick();
      set_idle();
      in_valid = 1; jump = 1; target_pc = 32'h80; pc_plus4 = 32'h10;
      tick();
      set_idle();
      n_checks++; if (in_ready !== 1'b0 || redirect_valid !== 1'b1) begin n_errors++; $display("FAIL rf_setup got ready %b redir %b exp 0/1", in_ready, redirect_valid); end
      reset = 1;
      tick();
      reset = 0;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL rf_state got valid %b ready %b exp 0/1", out_valid, in_ready); end
      n_checks++; if (redirect_valid !== 1'b0 || out_result !== 32'h0) begin n_errors++; $display("FAIL rf_clear got redir %b res %h exp 0/0", redirect_valid, out_result); end
      out_ready = 1;
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rf_stay_empty got %b exp 0", out_valid); end
   endtask

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      logic m_redir = 0, m_misal = 0;
      logic [31:0] m_rpc = 0;
      logic acc, cons, tk, mis;
      for (int cyc = 0; cyc < 800; cyc++) begin
         n_checks++; if (out_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, out_valid, q.size() != 0); end
         n_checks++; if (in_ready !== (q.size() < 2)) begin n_errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, in_ready, q.size() < 2); end
         n_checks++; if (redirect_valid !== m_redir || misalign_exc !== m_misal) begin n_errors++; $display("FAIL rnd_redir cyc %0d got %b/%b exp %b/%b", cyc, redirect_valid, misalign_exc, m_redir, m_misal); end
         if (m_redir) begin
            n_checks++; if (redirect_pc !== m_rpc) begin n_errors++; $display("FAIL rnd_rpc cyc %0d got %h exp %h", cyc, redirect_pc, m_rpc); end
         end
         if (q.size() != 0) begin
            e = q[0];
            n_checks++;
            if (out_result !== e.res || out_store_data !== e.sd || out_rd !== e.rd ||
                out_reg_write !== e.rw || out_mem_read !== e.mr || out_mem_write !== e.mw || out_funct3 !== e.f3) begin
               n_errors++;
               $display("FAIL rnd_beat cyc %0d got %h %h %0d %b%b%b %0d exp %h %h %0d %b%b%b %0d", cyc,
                        out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write, out_funct3,
                        e.res, e.sd, e.rd, e.rw, e.mr, e.mw, e.f3);
            end
         end
         // new random stimulus
         in_valid   = ($urandom_range(0, 9) < 7);
         out_ready  = ($urandom_range(0, 9) < 6);
         alu_result = $urandom();
         alu_zero   = 1'($urandom_range(0, 1));
         store_data = $urandom();
         rd         = 5'($urandom());
         reg_write  = 1'($urandom_range(0, 1));
         mem_read   = 1'($urandom_range(0, 1));
         mem_write  = 1'($urandom_range(0, 1));
         funct3     = 3'($urandom_range(0, 2));
         branch     = ($urandom_range(0, 9) < 2);
         jump       = ($urandom_range(0, 9) < 1);
         br_inv     = 1'($urandom_range(0, 1));
         target_pc  = $urandom();
         if ($urandom_range(0, 3) != 0) target_pc = {target_pc[31:2], 2'b00};
         pc_plus4   = $urandom();
         // reference model of the next edge
         tk   = jump || (branch && (alu_zero != br_inv));
         mis  = (target_pc % 4) != 0;
         acc  = in_valid && (q.size() < 2) && !(m_redir || m_misal);
         cons = (q.size() != 0) && out_ready;
         if (cons) void'(q.pop_front());
         if (acc) begin
            e.res = jump ? pc_plus4 : alu_result;
            e.sd  = store_data;
            e.rd  = rd;
            e.rw  = (tk && mis) ? 1'b0 : reg_write;
            e.mr  = (tk && mis) ? 1'b0 : mem_read;
            e.mw  = (tk && mis) ? 1'b0 : mem_write;
            e.f3  = funct3;
            q.push_back(e);
         end
         m_redir = acc && tk && !mis;
         m_misal = acc && tk && mis;
         if (acc && tk) m_rpc = target_pc;
         tick();
      end
      set_idle();
   endtask

   initial begin
      reset = 1;
      out_ready = 0;
      set_idle();
      test_reset();
      test_add();
      test_beq();
      test_bne();
      test_jal();
      test_back_to_back();
      test_misalign();
      test_reset_full();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
